// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux family: mode encodings and index-width helper.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for an N-way selection; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requester after `last`, wrapping at N-1.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]              req,
  input  logic [sel_width(N)-1:0]   last,
  output logic [sel_width(N)-1:0]   grant_idx,
  output logic                      grant_valid
);

  localparam int unsigned SELW = sel_width(N);

  int unsigned idx;

  // Offsets 1..N visit every channel once, ending at `last` itself.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last) + i) % N;
      if (!grant_valid && req[SELW'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer, fixed-select or round-robin, registered output.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N*W-1:0]                in_data,
  input  logic [N-1:0]                  in_valid,
  output logic [N-1:0]                  in_ready,
  input  logic [sel_width(N)-1:0]       sel,
  input  logic                          mode,
  output logic [W-1:0]                  out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [sel_width(N)-1:0]       out_ch
);

  localparam int unsigned SELW  = sel_width(N);
  localparam int unsigned NSPAN = 2 ** SELW;

  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic [SELW-1:0] last_grant_q, last_grant_d;

  logic            load;
  logic [SELW-1:0] rr_idx;
  logic            rr_valid;
  logic [SELW-1:0] grant_idx;
  logic            grant_valid;
  logic [NSPAN-1:0] valid_ext;

  rr_arbiter #(
    .N(N)
  ) u_rr_arbiter (
    .req        (in_valid),
    .last       (last_grant_q),
    .grant_idx  (rr_idx),
    .grant_valid(rr_valid)
  );

  assign load = !out_valid_q || out_ready;

  // Out-of-range select values land on the zero-padded upper bits and never grant.
  always_comb begin
    valid_ext        = '0;
    valid_ext[N-1:0] = in_valid;
    if (mode == MODE_RR) begin
      grant_idx   = rr_idx;
      grant_valid = rr_valid;
    end else begin
      grant_idx   = sel;
      grant_valid = valid_ext[sel];
    end
  end

  always_comb begin
    in_ready = '0;
    if (load && grant_valid) begin
      in_ready = N'(1) << grant_idx;
    end
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (load) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d   = in_data[grant_idx*W +: W];
        out_ch_d     = grant_idx;
        last_grant_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      last_grant_q <= SELW'(N - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed table-driven bench for stream_mux (N=4, W=8) plus hand sequences for reset and stalls.
module tb_stream_mux;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  int errors = 0;
  int checks = 0;

  stream_mux #(
    .N(4),
    .W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .mode     (mode),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_v;
    logic [7:0] exp_d;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] iv,
                              input logic ordy, input logic [3:0] rdy, input logic v,
                              input logic [7:0] d, input logic [1:0] ch);
    vec_t r;
    r.mode = m; r.sel = s; r.iv = iv; r.ordy = ordy;
    r.exp_rdy = rdy; r.exp_v = v; r.exp_d = d; r.exp_ch = ch;
    return r;
  endfunction

  // Drive at the falling edge, check in_ready mid-cycle, check registers just after the edge.
  task automatic step(input logic m, input logic [1:0] s, input logic [3:0] iv, input logic ordy,
                      input logic [3:0] rdy, input logic v, input logic [7:0] d,
                      input logic [1:0] ch, input string tag);
    @(negedge clk);
    mode = m; sel = s; in_valid = iv; out_ready = ordy;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      check({tag, ".out_data"}, 32'(out_data), 32'(d));
      check({tag, ".out_ch"}, 32'(out_ch), 32'(ch));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0; out_ready = 1'b1; mode = 1'b0; sel = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    // Fixed select, then round-robin from last_grant=2, then sparse/empty, then fixed corner cases.
    vecs[0]  = mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
    vecs[1]  = mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
    vecs[2]  = mk(1'b1, 2'd2, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3);
    vecs[3]  = mk(1'b1, 2'd2, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
    vecs[4]  = mk(1'b1, 2'd2, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
    vecs[5]  = mk(1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
    vecs[6]  = mk(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3);
    vecs[7]  = mk(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
    vecs[8]  = mk(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3);
    vecs[9]  = mk(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    vecs[10] = mk(1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
    vecs[11] = mk(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    vecs[12] = mk(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    vecs[13] = mk(1'b1, 2'd1, 4'b1101, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
    vecs[14] = mk(1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2);
    vecs[15] = mk(1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3);
    vecs[16] = mk(1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    vecs[17] = mk(1'b1, 2'd3, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);

    // Reset values
    do_reset();
    #1;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_data", 32'(out_data), 32'd0);
    check("reset.out_ch", 32'(out_ch), 32'd0);

    // Round-robin from reset: channel 0 first, then back-to-back rotation
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, "rr0");
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, "rr1");
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2, "rr2");
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3, "rr3");
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, "rr4");
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, "rr5");

    // Asynchronous reset mid-stream, clear visible before any clock edge
    @(negedge clk);
    #2;
    check("pre_areset.out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("areset.out_valid", 32'(out_valid), 32'd0);
    check("areset.out_data", 32'(out_data), 32'd0);
    check("areset.out_ch", 32'(out_ch), 32'd0);
    check("areset.in_ready", 32'(in_ready), 32'b0001);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].mode, vecs[i].sel, vecs[i].iv, vecs[i].ordy, vecs[i].exp_rdy,
           vecs[i].exp_v, vecs[i].exp_d, vecs[i].exp_ch, $sformatf("vec%0d", i));
    end

    // Backpressure: held word from vec17 (ch0) must stay put for three stalled cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0, $sformatf("stall%0d", i));
    end
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, "unstall");
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2, "unstall_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
